// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V datapath: opcodes, ALU-control
// codes, datapath select encodings and the main control FSM state enum.
package riscv_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // Also consumed by the ALU control stage.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8
    } state_t;

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RISC-V datapath: sequences lw, sw,
// R-type and beq through fetch/decode/execute/memory/write-back states.
module multicycle_control
    import riscv_pkg::*;
#(
    parameter bit WAIT_MEM = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic       illegalInstr,
    output logic [3:0] state
);

    state_t r_state;
    state_t w_state_next;
    logic   r_illegal;
    logic   w_mem_ready;
    logic   w_decode_illegal;

    // Without memory handshaking every access is treated as single-cycle.
    assign w_mem_ready      = WAIT_MEM ? memReady : 1'b1;
    assign w_decode_illegal = (r_state == S_DECODE) && !is_supported(opcode);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_decode_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH: begin
                w_state_next = w_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    w_state_next = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    w_state_next = S_EXECR;
                end else if (opcode == OP_BEQ) begin
                    w_state_next = S_BEQ;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_MEMADR: begin
                // IR is stable, so the opcode seen in DECODE is still valid here.
                if (opcode == OP_LW) begin
                    w_state_next = S_MEMREAD;
                end else if (opcode == OP_SW) begin
                    w_state_next = S_MEMWRITE;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_MEMREAD: begin
                w_state_next = w_mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                w_state_next = w_mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                w_state_next = S_ALUWB;
            end
            S_ALUWB: begin
                w_state_next = S_FETCH;
            end
            S_BEQ: begin
                w_state_next = S_FETCH;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    always_comb begin
        pcWrite   = 1'b0;
        adrSrc    = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        regWrite  = 1'b0;
        resultSrc = RES_ALUOUT;
        aluSrcA   = SRCA_PC;
        aluSrcB   = SRCB_REGB;
        aluOp     = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                memRead   = 1'b1;
                adrSrc    = 1'b0;
                aluSrcA   = SRCA_PC;
                aluSrcB   = SRCB_FOUR;
                aluOp     = ALUOP_ADD;
                resultSrc = RES_ALURESULT;
                irWrite   = w_mem_ready;
                pcWrite   = w_mem_ready;
            end
            S_DECODE: begin
                // Branch target PC+imm is parked in ALUOut for a possible beq.
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
                aluOp   = ALUOP_ADD;
            end
            S_MEMADR: begin
                aluSrcA = SRCA_REGA;
                aluSrcB = SRCB_IMM;
                aluOp   = ALUOP_ADD;
            end
            S_MEMREAD: begin
                adrSrc  = 1'b1;
                memRead = 1'b1;
            end
            S_MEMWB: begin
                resultSrc = RES_DATA;
                regWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
            end
            S_EXECR: begin
                aluSrcA = SRCA_REGA;
                aluSrcB = SRCB_REGB;
                aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                resultSrc = RES_ALUOUT;
                regWrite  = 1'b1;
            end
            S_BEQ: begin
                aluSrcA   = SRCA_REGA;
                aluSrcB   = SRCB_REGB;
                aluOp     = ALUOP_SUB;
                resultSrc = RES_ALUOUT;
                pcWrite   = zero;
            end
            default: begin
                pcWrite = 1'b0;
            end
        endcase

        // During reset nothing may be written; selects idle at their FETCH values.
        if (reset) begin
            pcWrite   = 1'b0;
            irWrite   = 1'b0;
            regWrite  = 1'b0;
            memRead   = 1'b0;
            memWrite  = 1'b0;
            adrSrc    = 1'b0;
            resultSrc = RES_ALURESULT;
            aluSrcA   = SRCA_PC;
            aluSrcB   = SRCB_FOUR;
            aluOp     = ALUOP_ADD;
        end
    end

    assign illegalInstr = r_illegal;
    assign state        = r_state;

endmodule
